line_window_gen: RTL and testbench
==================================

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per line (legal >= 3).
REQ-003 SHALL have parameter IMG_H, default 480, lines per frame (legal >= 2).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sof, input, 1, marks the current pix_valid beat as pixel (0,0) of a new frame.
REQ-007 SHALL have port pix_valid, input, 1, pixel beat present.
REQ-008 SHALL have port pix_data, input, DATA_WIDTH, raster-order pixel.
REQ-009 SHALL have port pix_ready, output, 1; a beat is accepted when pix_valid && pix_ready.
REQ-010 SHALL have ports lineK_dataJ (K,J in 0..2), output, DATA_WIDTH each, the 3x3 window: line0 = row below centre, line1 = centre row, line2 = row above; data0 = column right of centre, data1 = centre column, data2 = column left.
REQ-011 SHALL have port corner_type, output, 4, border code of the centre pixel.
REQ-012 SHALL have port win_valid, output, 1, window outputs valid this cycle; no output backpressure.

Function
REQ-013 SHALL implement states IDLE, FILL, RUN, FLUSH.
REQ-014 SHALL define an advance event as an accepted beat (IDLE/FILL/RUN) or any FLUSH cycle.
REQ-015 SHALL store the last 2*IMG_W+3 advanced pixels (two line buffers plus 3x3 register window); in FLUSH the shifted-in value is 0.
REQ-016 SHALL emit the window centred on pixel index n (raster index r*IMG_W+c) on the advance that shifts in index n+IMG_W+1, giving a fixed lag of IMG_W+1 advances.
REQ-017 SHALL register all window outputs, corner_type and win_valid, asserting them the cycle after the causing advance.
REQ-018 SHALL drive 0 on every tap lying outside the frame (r-1<0, r+1>IMG_H-1, c-1<0, c+1>IMG_W-1), including wrapped pixels from the adjacent line.
REQ-019 SHALL set corner_type: (0,0)->1; (0,IMG_W-1)->2; c=0 with 0<r<IMG_H-1 ->3; c=IMG_W-1 with 0<r<IMG_H-1 ->4; (IMG_H-1,0)->5; (IMG_H-1,IMG_W-1)->6; all other centres ->8.
REQ-020 SHALL drive corner_type 0 and all taps 0 when win_valid is low.
REQ-021 SHALL transition IDLE->FILL on the first accepted beat; FILL->RUN when IMG_W+1 beats accepted; RUN->FLUSH after the IMG_W*IMG_H-th beat is accepted.
REQ-022 SHALL hold pix_ready low throughout FLUSH, run exactly IMG_W+1 FLUSH cycles, then return to IDLE with pix_ready high.
REQ-023 SHALL keep output row/column counters tracking the centre, wrapping column IMG_W-1->0 with row increment.
REQ-024 SHALL, on sof with an accepted beat in any non-FLUSH state, discard the partial frame (no further windows from it), clear counters, and treat that beat as pixel (0,0) in FILL.
REQ-025 SHALL ignore sof without pix_valid; SHALL ignore sof during FLUSH (pix_ready low).
REQ-026 SHALL, when pix_valid is low in FILL/RUN, hold all state and deassert win_valid.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, counters 0, win_valid 0, corner_type 0, all taps 0, pix_ready 1.
REQ-028 SHALL, on reset assertion mid-frame or mid-flush, abandon the frame; line buffer contents need not be cleared but SHALL never appear on outputs as in-frame data.

Verification (IMG_W=4, IMG_H=3, DATA_WIDTH=8)
REQ-029 Stream values 1..12 continuously from reset -> first win_valid the cycle after value 6 accepted: line1={2,1,0}, line0={6,5,0}, line2={0,0,0}, corner_type=1.
REQ-030 Same stream -> exactly 12 windows, corner_type sequence 1,8,8,2,3,8,8,4,5,8,8,6; window with centre 7: line2={4,3,2}, line1={8,7,6}, line0={12,11,10}, corner_type=8.
REQ-031 After value 12 accepted -> pix_ready low for exactly 5 cycles, 5 windows emitted, last: line1={0,12,11}, line2={0,8,7}, line0=0s, corner_type=6; then pix_ready high, state IDLE.
REQ-032 pix_valid deasserted for 3 cycles after value 7 -> no win_valid in the gap; remaining windows identical to REQ-030.
REQ-033 sof with value 50 after 7 beats of a frame -> no further old-frame windows; new frame's first window (after 5 more beats) has centre 50, corner_type 1.
REQ-034 rst_n low for one cycle during FLUSH -> all outputs 0, pix_ready 1 immediately; next 12-beat frame reproduces REQ-030.

Source files
------------

// File: rtl/line_window_gen.sv
// line_window_gen: 3x3 raster window generator with line buffers, border zeroing and corner codes.
module line_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] line0_data0,
  output logic [DATA_WIDTH-1:0] line0_data1,
  output logic [DATA_WIDTH-1:0] line0_data2,
  output logic [DATA_WIDTH-1:0] line1_data0,
  output logic [DATA_WIDTH-1:0] line1_data1,
  output logic [DATA_WIDTH-1:0] line1_data2,
  output logic [DATA_WIDTH-1:0] line2_data0,
  output logic [DATA_WIDTH-1:0] line2_data1,
  output logic [DATA_WIDTH-1:0] line2_data2,
  output logic [3:0]            corner_type,
  output logic                  win_valid
);
  localparam int N  = 2 * IMG_W + 3;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(IMG_W * IMG_H + IMG_W + 2);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t st_q, st_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] cr_q, cr_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [N-1:0][DATA_WIDTH-1:0] sr_q, sr_d;
  logic [2:0][2:0][DATA_WIDTH-1:0] tap_q, tap_d;
  logic [3:0] corner_q, corner_d;
  logic wv_q, wv_d;
  logic adv, start, emit, top, bot, lft, rgt;
  // sr index 0 is the newest pixel; the centre sits IMG_W+1 advances back
  always_comb begin
    adv = (st_q == FLUSH) || pix_valid;
    start = pix_valid && (st_q != FLUSH) && (sof || st_q == IDLE);
    emit = adv && !start && (st_q == RUN || st_q == FLUSH);
    sr_d = adv ? {sr_q[N-2:0], (st_q == FLUSH) ? {DATA_WIDTH{1'b0}} : pix_data} : sr_q;
    cnt_d = start ? NW'(1) : adv ? cnt_q + 1'b1 : cnt_q;
    st_d = start ? FILL
         : (st_q == FILL && adv && cnt_d == NW'(IMG_W + 1)) ? RUN
         : (st_q == RUN && adv && cnt_d == NW'(IMG_W * IMG_H)) ? FLUSH
         : (st_q == FLUSH && cnt_d == NW'(IMG_W * IMG_H + IMG_W + 1)) ? IDLE
         : st_q;
    top = cr_q == '0;
    bot = cr_q == RW'(IMG_H - 1);
    lft = cc_q == '0;
    rgt = cc_q == CW'(IMG_W - 1);
    corner_d = !emit ? 4'd0 : (top && lft) ? 4'd1 : (top && rgt) ? 4'd2
             : (bot && lft) ? 4'd5 : (bot && rgt) ? 4'd6 : lft ? 4'd3 : rgt ? 4'd4 : 4'd8;
    tap_d = '0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        tap_d[k][j] = (emit && !(k == 0 && bot) && !(k == 2 && top) && !(j == 0 && rgt) && !(j == 2 && lft))
                    ? sr_d[k * IMG_W + j] : {DATA_WIDTH{1'b0}};
    wv_d = emit;
    cc_d = start ? '0 : !emit ? cc_q : rgt ? '0 : cc_q + 1'b1;
    cr_d = start ? '0 : (!emit || !rgt) ? cr_q : bot ? '0 : cr_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
      cr_q <= '0;
      cc_q <= '0;
      tap_q <= '0;
      corner_q <= '0;
      wv_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      cr_q <= cr_d;
      cc_q <= cc_d;
      tap_q <= tap_d;
      corner_q <= corner_d;
      wv_q <= wv_d;
    end
  end
  always_ff @(posedge clk) sr_q <= sr_d;
  assign pix_ready = st_q != FLUSH;
  assign line0_data0 = tap_q[0][0];
  assign line0_data1 = tap_q[0][1];
  assign line0_data2 = tap_q[0][2];
  assign line1_data0 = tap_q[1][0];
  assign line1_data1 = tap_q[1][1];
  assign line1_data2 = tap_q[1][2];
  assign line2_data0 = tap_q[2][0];
  assign line2_data1 = tap_q[2][1];
  assign line2_data2 = tap_q[2][2];
  assign corner_type = corner_q;
  assign win_valid = wv_q;
endmodule

// File: tb/tb_line_window_gen.sv
// tb_line_window_gen: directed checks of the 3x3 window generator on a 4x3 frame.
module tb_line_window_gen;
  logic clk = 1'b0, rst_n = 1'b0, sof = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic pix_ready, win_valid;
  logic [3:0] corner_type;
  logic [7:0] line0_data0, line0_data1, line0_data2;
  logic [7:0] line1_data0, line1_data1, line1_data2;
  logic [7:0] line2_data0, line2_data1, line2_data2;
  int n_cmp = 0, n_bad = 0;
  int cs [12] = '{1, 8, 8, 2, 3, 8, 8, 4, 5, 8, 8, 6};
  line_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(3)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready),
    .line0_data0(line0_data0), .line0_data1(line0_data1), .line0_data2(line0_data2),
    .line1_data0(line1_data0), .line1_data1(line1_data1), .line1_data2(line1_data2),
    .line2_data0(line2_data0), .line2_data1(line2_data1), .line2_data2(line2_data2),
    .corner_type(corner_type), .win_valid(win_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [71:0] o, input logic [71:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic lines(input string tag, input logic [23:0] l0, input logic [23:0] l1, input logic [23:0] l2);
    chk({tag, "_line0"}, {line0_data0, line0_data1, line0_data2}, l0);
    chk({tag, "_line1"}, {line1_data0, line1_data1, line1_data2}, l1);
    chk({tag, "_line2"}, {line2_data0, line2_data1, line2_data2}, l2);
  endtask
  task automatic win(input string tag, input int n, input int cv);
    chk({tag, "_valid"}, win_valid, n >= 0);
    chk({tag, "_corner"}, corner_type, n >= 0 ? cs[n] : 0);
    chk({tag, "_centre"}, line1_data1, n >= 0 ? cv : 0);
  endtask
  task automatic beat(input logic [7:0] v, input logic s, input int n, input int cv);
    pix_valid = 1'b1;
    sof = s;
    pix_data = v;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    sof = 1'b0;
    win("beat", n, cv);
  endtask
  task automatic fl(input int n, input int cv, input logic pr);
    @(posedge clk); #1;
    win("flush", n, cv);
    chk("flush_ready", pix_ready, pr);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", pix_ready, 1'b1);
    chk("rst_outs", {win_valid, corner_type, line0_data0, line0_data1, line0_data2, line1_data0,
                     line1_data1, line1_data2, line2_data0, line2_data1, line2_data2}, '0);
    rst_n = 1'b1;
    // frame A: values 1..12, then flush while sof/pix_valid are held high
    for (int i = 0; i < 12; i++) begin
      beat(8'(i + 1), i == 0, i - 5, i - 4);
      if (i == 5) lines("first", {8'd6, 8'd5, 8'd0}, {8'd2, 8'd1, 8'd0}, 24'd0);
      if (i == 11) lines("c7", {8'd12, 8'd11, 8'd10}, {8'd8, 8'd7, 8'd6}, {8'd4, 8'd3, 8'd2});
    end
    chk("a_ready_low", pix_ready, 1'b0);
    pix_valid = 1'b1;
    sof = 1'b1;
    pix_data = 8'd99;
    for (int f = 0; f < 5; f++) fl(7 + f, 8 + f, f == 4);
    pix_valid = 1'b0;
    sof = 1'b0;
    lines("last", 24'd0, {8'd0, 8'd12, 8'd11}, {8'd0, 8'd8, 8'd7});
    @(posedge clk); #1;
    win("a_idle", -1, 0);
    // frame restarted by sof after 7 beats
    for (int i = 0; i < 7; i++) beat(8'(i + 1), i == 0, i - 5, i - 4);
    beat(8'd50, 1'b1, -1, 0);
    for (int i = 1; i < 5; i++) beat(8'(50 + i), 1'b0, -1, 0);
    beat(8'd55, 1'b0, 0, 50);
    lines("sof", {8'd55, 8'd54, 8'd0}, {8'd51, 8'd50, 8'd0}, 24'd0);
    for (int i = 6; i < 12; i++) beat(8'(50 + i), 1'b0, i - 5, 50 + i - 5);
    fl(7, 57, 1'b0);
    // reset pulse in the middle of the flush
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", pix_ready, 1'b1);
    chk("mid_rst_outs", {win_valid, corner_type, line0_data0, line0_data1, line0_data2, line1_data0,
                         line1_data1, line1_data2, line2_data0, line2_data1, line2_data2}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", pix_ready, 1'b1);
    win("post_rst", -1, 0);
    // frame B with a 3-cycle pix_valid gap after value 7
    for (int i = 0; i < 12; i++) begin
      beat(8'(i + 1), i == 0, i - 5, i - 4);
      if (i == 6)
        repeat (3) begin
          @(posedge clk); #1;
          win("gap", -1, 0);
        end
      if (i == 11) lines("b_c7", {8'd12, 8'd11, 8'd10}, {8'd8, 8'd7, 8'd6}, {8'd4, 8'd3, 8'd2});
    end
    for (int f = 0; f < 5; f++) fl(7 + f, 8 + f, f == 4);
    lines("b_last", 24'd0, {8'd0, 8'd12, 8'd11}, {8'd0, 8'd8, 8'd7});
    @(posedge clk); #1;
    win("b_idle", -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
